wb_spi_link_master: RTL
=======================

WB_SPI_LINK_MASTER -- requirements
Module: wb_spi_link_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning SCLK half-period in wb_clk_i cycles (legal range 1..255).
REQ-002 SHALL have ports, clock and reset first:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_addr_i  in  16  register select; only [1:0] decoded
- wb_data_i  in  32  write data
- wb_data_o  out  32  read data
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic strobes
- wb_sel_i  in  4  ignored; all accesses full-word
- wb_ack_o  out  1  acknowledge
- spi_cs_n_o  out  1  slave select, active-low
- spi_sclk_o  out  1  serial clock
- spi_mosi_o  out  1  master out
- spi_miso_i  in  1  master in
- irq_o  out  1  frame-complete pulse
REQ-003 SHALL decode registers by wb_addr_i[1:0]:
- 0 CTRL/STAT: write bit0=START, bit1=WR (1=write frame); read bit0=BUSY, bit1=DONE
- 1 ADDR: [15:0] R/W
- 2 TXDATA: R/W
- 3 RXDATA: read-only

Function
REQ-004 SHALL assert wb_ack_o for exactly one cycle, registered one cycle after wb_cyc_i&wb_stb_i, never on consecutive cycles (ack <= cyc&stb&~ack).
REQ-005 SHALL perform register writes and load wb_data_o on the cycle wb_ack_o is set; unused read bits return 0.
REQ-006 SHALL ignore writes to ADDR, TXDATA and START while BUSY=1; the bus access is still acknowledged.
REQ-007 SHALL treat START=1 while idle as frame acceptance: latch WR, set BUSY, clear DONE, all in the acceptance cycle.
REQ-008 SHALL send a 56-bit frame, MSB first: command byte (bit7=WR, bits6:0=0), ADDR[15:0], then 32 data bits (TXDATA on write frames, zeros on read frames).
REQ-009 SHALL use SPI mode 0: SCLK idle low; MOSI changes at the start of each SCLK low phase; MISO sampled in the cycle SCLK rises.
REQ-010 SHALL implement FSM IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> IDLE.
- IDLE: cs_n=1, sclk=0
- CS_SETUP: cs_n=0 from the cycle after acceptance, for CLK_DIV cycles; MOSI=bit55
- SHIFT: 56 bits, each CLK_DIV cycles low then CLK_DIV cycles high
- CS_HOLD: sclk=0 for CLK_DIV cycles
REQ-011 SHALL keep cs_n low for exactly 114*CLK_DIV cycles per frame, with exactly 56 SCLK rising edges.
REQ-012 SHALL use an 8-bit half-period counter and a 6-bit bit counter; the bit counter terminates at 55 without wrap.
REQ-013 SHALL, on read frames only, shift MISO samples from the last 32 rising edges into RXDATA, first sample into bit31; write frames leave RXDATA unchanged.
REQ-014 SHALL, on the cycle cs_n returns high, clear BUSY, set DONE and pulse irq_o for one cycle; DONE stays set until the next accepted START.
REQ-015 SHALL ignore START written in the same cycle the frame completes; it applies only once BUSY reads 0.
REQ-016 SHALL drive MOSI to 0 when IDLE.

Reset
REQ-017 SHALL, on wb_rst_i, asynchronously force IDLE and set cs_n=1, sclk=0, mosi=0, wb_ack_o=0, wb_data_o=0, irq_o=0, BUSY=0, DONE=0, ADDR=0, TXDATA=0, RXDATA=0, including mid-frame.
REQ-018 SHALL begin no new frame after reset until a new START is written.

Verification (CLK_DIV=2)
REQ-019 Reset: assert wb_rst_i -> all outputs at their REQ-017 values; read CTRL returns 0x0.
REQ-020 Write frame: ADDR=0x0012, TXDATA=0xDEADBEEF, CTRL=0x3 -> MOSI stream 0x800012DEADBEEF over 56 rising edges; cs_n low 228 cycles; one irq_o pulse; CTRL reads 0x2.
REQ-021 Read frame: ADDR=0x0040, CTRL=0x1, slave model drives 0xA5A55A5A in the data phase -> MOSI 0x00004000000000; RXDATA reads 0xA5A55A5A.
REQ-022 Busy protection: mid-frame, write ADDR=0xFFFF, TXDATA=0, CTRL=0x3 -> each acknowledged; frame bits unchanged; ADDR still reads 0x0012; exactly one frame sent.
REQ-023 Reset mid-frame: assert wb_rst_i at bit 20 -> cs_n=1 and sclk=0 immediately; no irq_o; a following START runs a complete, correct frame.
REQ-024 Bus timing: back-to-back held cyc/stb -> ack toggles 1,0,1; each read returns the current register value.

Source files
------------

// File: rtl/wb_spi_link_master.sv
// Wishbone-slave register block driving a 56-bit SPI mode-0 link frame:
// command byte, 16-bit address, 32-bit data; read frames capture 32 MISO bits.
module wb_spi_link_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        spi_cs_n_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        irq_o
);

  localparam int unsigned FRAME_BITS = 56;
  localparam int unsigned RX_BITS    = 32;
  localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [5:0]  BIT_LAST   = 6'(FRAME_BITS - 1);
  localparam logic [5:0]  RX_FIRST   = 6'(FRAME_BITS - RX_BITS);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              div_q, div_d;
  logic [5:0]              bit_q, bit_d;
  logic [FRAME_BITS-1:0]   sh_q, sh_d;
  logic [31:0]             rx_q, rx_d;
  logic [15:0]             addr_q;
  logic [31:0]             tx_q;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    wr_q, wr_d;
  logic                    sclk_d, cs_n_d, mosi_d, irq_d;
  logic                    bus_req_c, start_c, div_last_c;
  logic [31:0]             rd_mux_c;
  logic                    unused_c;

  assign unused_c   = ^{wb_sel_i, wb_addr_i[15:2]};
  assign bus_req_c  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign start_c    = bus_req_c & wb_we_i & (wb_addr_i[1:0] == 2'd0) & wb_data_i[0] & ~busy_q;
  assign div_last_c = (div_q == DIV_LAST);

  // Read-data mux; unused bits return zero
  always_comb begin
    rd_mux_c = '0;
    case (wb_addr_i[1:0])
      2'd0:    rd_mux_c = {30'h0, done_q, busy_q};
      2'd1:    rd_mux_c = {16'h0, addr_q};
      2'd2:    rd_mux_c = tx_q;
      default: rd_mux_c = rx_q;
    endcase
  end

  // Bus handshake and software-visible ADDR/TXDATA registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o  <= 1'b0;
      wb_data_o <= '0;
      addr_q    <= '0;
      tx_q      <= '0;
    end else begin
      wb_ack_o <= bus_req_c;
      if (bus_req_c) begin
        wb_data_o <= rd_mux_c;
        if (wb_we_i && !busy_q) begin
          if (wb_addr_i[1:0] == 2'd1) addr_q <= wb_data_i[15:0];
          if (wb_addr_i[1:0] == 2'd2) tx_q   <= wb_data_i;
        end
      end
    end
  end

  // Frame sequencer: next state and next values of all link outputs
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    wr_d    = wr_q;
    sclk_d  = spi_sclk_o;
    cs_n_d  = spi_cs_n_o;
    mosi_d  = spi_mosi_o;
    irq_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = CS_SETUP;
          div_d   = '0;
          bit_d   = '0;
          sh_d    = {wb_data_i[1], 7'h0, addr_q, (wb_data_i[1] ? tx_q : 32'h0)};
          mosi_d  = wb_data_i[1];
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          wr_d    = wb_data_i[1];
        end
      end
      CS_SETUP: begin
        if (div_last_c) begin
          state_d = SHIFT;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
        if (!div_last_c) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (!spi_sclk_o) begin
            // Rising edge: sample MISO into RXDATA during the data phase of read frames
            sclk_d = 1'b1;
            if (!wr_q && bit_q >= RX_FIRST) rx_d = {rx_q[30:0], spi_miso_i};
          end else if (bit_q == BIT_LAST) begin
            sclk_d  = 1'b0;
            state_d = CS_HOLD;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 6'd1;
            sh_d   = {sh_q[FRAME_BITS-2:0], 1'b0};
            mosi_d = sh_q[FRAME_BITS-2];
          end
        end
      end
      CS_HOLD: begin
        if (div_last_c) begin
          state_d = IDLE;
          div_d   = '0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          irq_d   = 1'b1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered link outputs
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_q       <= 1'b0;
      spi_sclk_o <= 1'b0;
      spi_cs_n_o <= 1'b1;
      spi_mosi_o <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_q       <= wr_d;
      spi_sclk_o <= sclk_d;
      spi_cs_n_o <= cs_n_d;
      spi_mosi_o <= mosi_d;
      irq_o      <= irq_d;
    end
  end

endmodule
